// File: rtl/stream_wrr_arbiter_pkg.sv
// Shared types and helpers for the packet-granular weighted round-robin stream arbiter.
package stream_arb_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      BURST = 1'b1
   } arb_state_e;

   // Widest QoS field the credit helper accepts; credit width tracks the QoS width.
   localparam int unsigned QOS_W_MAX = 16;

   // A weight of zero still earns one packet per grant.
   function automatic logic [QOS_W_MAX-1:0] qos_to_credit(input logic [QOS_W_MAX-1:0] qos);
      return (qos == '0) ? QOS_W_MAX'(1) : qos;
   endfunction

endpackage

// File: rtl/stream_wrr_arbiter_if.sv
// Stream bundle between the per-source producers, the arbiter and the downstream consumer.
interface stream_wrr_arbiter_if #(
   parameter int unsigned T_DATA_WIDTH = 8,
   parameter int unsigned T_QOS__WIDTH = 4,
   parameter int unsigned STREAM_COUNT = 2
);
   localparam int unsigned ID_W = $clog2(STREAM_COUNT);

   logic [T_DATA_WIDTH-1:0] s_data_i [STREAM_COUNT];
   logic [T_QOS__WIDTH-1:0] s_qos_i  [STREAM_COUNT];
   logic [STREAM_COUNT-1:0] s_last_i;
   logic [STREAM_COUNT-1:0] s_valid_i;
   logic [STREAM_COUNT-1:0] s_ready_o;

   logic [T_DATA_WIDTH-1:0] m_data_o;
   logic [T_QOS__WIDTH-1:0] m_qos_o;
   logic [ID_W-1:0]         m_id_o;
   logic                    m_last_o;
   logic                    m_valid_o;
   logic                    m_ready_i;

   modport slave (
      input  s_data_i, s_qos_i, s_last_i, s_valid_i, m_ready_i,
      output s_ready_o, m_data_o, m_qos_o, m_id_o, m_last_o, m_valid_o
   );

   modport master (
      output s_data_i, s_qos_i, s_last_i, s_valid_i, m_ready_i,
      input  s_ready_o, m_data_o, m_qos_o, m_id_o, m_last_o, m_valid_o
   );

endinterface

// File: rtl/stream_wrr_arbiter_rr_pick.sv
// Rotating priority encoder: first set bit of valid searching upward from last_id+1 (mod N).
module rr_pick #(
   parameter int unsigned N    = 2,
   parameter int unsigned ID_W = 1
) (
   input  logic [N-1:0]    valid,
   input  logic [ID_W-1:0] last_id,
   output logic            found,
   output logic [ID_W-1:0] idx
);

   int unsigned     cand;
   logic [ID_W-1:0] cand_id;

   // Offsets are scanned farthest-first so the nearest valid stream is the last one written.
   always_comb begin
      found   = 1'b0;
      idx     = '0;
      cand    = 0;
      cand_id = '0;
      for (int unsigned k = 0; k < N; k++) begin
         cand    = (32'(last_id) + N - k) % N;
         cand_id = ID_W'(cand);
         if (valid[cand_id]) begin
            found = 1'b1;
            idx   = cand_id;
         end
      end
   end

endmodule

// File: rtl/stream_wrr_arbiter.sv
// Packet-granular weighted round-robin arbiter; define WRR_QOS_WEIGHT_EN for QoS-weighted
// credit, otherwise every grant carries exactly one packet. T_QOS__WIDTH must not exceed QOS_W_MAX.
module stream_wrr_arbiter
   import stream_arb_pkg::*;
#(
   parameter int unsigned T_DATA_WIDTH = 8,
   parameter int unsigned T_QOS__WIDTH = 4,
   parameter int unsigned STREAM_COUNT = 2
) (
   input  logic                clk,
   input  logic                rst_n,
   stream_wrr_arbiter_if.slave bus
);

   localparam int unsigned ID_W     = $clog2(STREAM_COUNT);
   localparam int unsigned CREDIT_W = T_QOS__WIDTH;

   arb_state_e              state_q, state_d;
   logic [ID_W-1:0]         grant_q, grant_d;
   logic [ID_W-1:0]         last_id_q, last_id_d;
   logic [CREDIT_W-1:0]     credit_q, credit_d;
   logic                    in_pkt_q, in_pkt_d;

   logic                    pick_found;
   logic [ID_W-1:0]         pick_idx;
   logic [CREDIT_W-1:0]     credit_load;
   logic                    out_free;
   logic                    accept;
   logic [STREAM_COUNT-1:0] s_ready_c;

   logic [T_DATA_WIDTH-1:0] m_data_q;
   logic [T_QOS__WIDTH-1:0] m_qos_q;
   logic [ID_W-1:0]         m_id_q;
   logic                    m_last_q;
   logic                    m_valid_q;

   rr_pick #(
      .N    (STREAM_COUNT),
      .ID_W (ID_W)
   ) u_rr_pick (
      .valid   (bus.s_valid_i),
      .last_id (last_id_q),
      .found   (pick_found),
      .idx     (pick_idx)
   );

`ifdef WRR_QOS_WEIGHT_EN
   assign credit_load = CREDIT_W'(qos_to_credit(QOS_W_MAX'(bus.s_qos_i[pick_idx])));
`else
   assign credit_load = CREDIT_W'(1);
`endif

   // Output slot can take a beat when empty or draining this cycle.
   assign out_free = !m_valid_q || bus.m_ready_i;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         grant_q   <= '0;
         last_id_q <= ID_W'(STREAM_COUNT - 1);
         credit_q  <= '0;
         in_pkt_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         grant_q   <= grant_d;
         last_id_q <= last_id_d;
         credit_q  <= credit_d;
         in_pkt_q  <= in_pkt_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      grant_d   = grant_q;
      last_id_d = last_id_q;
      credit_d  = credit_q;
      in_pkt_d  = in_pkt_q;
      s_ready_c = '0;
      accept    = 1'b0;
      case (state_q)
         IDLE: begin
            if (pick_found) begin
               grant_d  = pick_idx;
               credit_d = credit_load;
               state_d  = BURST;
            end
         end
         BURST: begin
            s_ready_c[grant_q] = out_free;
            accept             = out_free && bus.s_valid_i[grant_q];
            if (accept) begin
               if (bus.s_last_i[grant_q]) begin
                  in_pkt_d = 1'b0;
                  credit_d = credit_q - CREDIT_W'(1);
                  if (credit_q == CREDIT_W'(1)) begin
                     last_id_d = grant_q;
                     state_d   = IDLE;
                  end
               end else begin
                  in_pkt_d = 1'b1;
               end
            end else if (!in_pkt_q && !bus.s_valid_i[grant_q]) begin
               // Source went quiet between packets: give up the rest of the credit.
               credit_d  = '0;
               last_id_d = grant_q;
               state_d   = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_data_q  <= '0;
         m_qos_q   <= '0;
         m_id_q    <= '0;
         m_last_q  <= 1'b0;
         m_valid_q <= 1'b0;
      end else if (accept) begin
         m_data_q  <= bus.s_data_i[grant_q];
         m_qos_q   <= bus.s_qos_i[grant_q];
         m_id_q    <= grant_q;
         m_last_q  <= bus.s_last_i[grant_q];
         m_valid_q <= 1'b1;
      end else if (bus.m_ready_i) begin
         m_valid_q <= 1'b0;
      end
   end

   assign bus.s_ready_o = s_ready_c;
   assign bus.m_data_o  = m_data_q;
   assign bus.m_qos_o   = m_qos_q;
   assign bus.m_id_o    = m_id_q;
   assign bus.m_last_o  = m_last_q;
   assign bus.m_valid_o = m_valid_q;

endmodule

// File: tb/tb_stream_wrr_arbiter.sv
// Bench for stream_wrr_arbiter: directed scenarios plus random traffic against a transaction-level model.
module tb_stream_wrr_arbiter;

   localparam int unsigned DW = 8;
   localparam int unsigned QW = 4;
   localparam int unsigned N  = 2;

   typedef struct {
      logic [DW-1:0] data;
      logic          last;
   } beat_t;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   stream_wrr_arbiter_if #(.T_DATA_WIDTH(DW), .T_QOS__WIDTH(QW), .STREAM_COUNT(N)) bus ();

   stream_wrr_arbiter #(.T_DATA_WIDTH(DW), .T_QOS__WIDTH(QW), .STREAM_COUNT(N)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int vectors    = 0;
   int miscompares = 0;

   beat_t         src_q [N][$];
   bit            want  [N];
   logic [QW-1:0] qos_in [N];
   logic          mready;

   // Reference model: owner of the output (-1 = nobody), packets left, packet-open flag, output slot.
   int            own, last_own, cred;
   bit            mid;
   bit            ev, el;
   logic [DW-1:0] ed;
   logic [QW-1:0] eq;
   int            eid;
   int            last_acc;

   int obs_ids [$];
   int exp_ids [$];
   int xfers, beats_gen;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int weight(input logic [QW-1:0] q);
`ifdef WRR_QOS_WEIGHT_EN
      return (q == '0) ? 1 : int'(q);
`else
      return 1;
`endif
   endfunction

   task automatic add_pkt(input int s, input int len);
      beat_t b;
      for (int i = 0; i < len; i++) begin
         b.data = DW'($urandom);
         b.last = (i == len - 1);
         src_q[s].push_back(b);
      end
      beats_gen += len;
   endtask

   task automatic drive();
      for (int s = 0; s < N; s++) begin
         bus.s_valid_i[s] = (src_q[s].size() > 0) && want[s];
         bus.s_data_i[s]  = (src_q[s].size() > 0) ? src_q[s][0].data : '0;
         bus.s_last_i[s]  = (src_q[s].size() > 0) ? src_q[s][0].last : 1'b0;
         bus.s_qos_i[s]   = qos_in[s];
      end
      bus.m_ready_i = mready;
   endtask

   task automatic model_reset();
      own = -1; last_own = N - 1; cred = 0; mid = 0;
      ev = 0; el = 0; ed = '0; eq = '0; eid = 0; last_acc = -1;
   endtask

   // One clock: apply inputs, check ready, advance the model, check the registered outputs.
   task automatic step();
      bit             v [N];
      logic [N-1:0]   exp_rdy;
      int             acc;
      int             c;
      bit             got;
      beat_t          b;
      drive();
      #1;
      for (int s = 0; s < N; s++) v[s] = (src_q[s].size() > 0) && want[s];
      exp_rdy = '0;
      acc     = -1;
      if (own >= 0) begin
         exp_rdy[own] = !ev || mready;
         if (exp_rdy[own] && v[own]) acc = own;
      end
      chk("s_ready", 32'(bus.s_ready_o), 32'(exp_rdy));
      if (bus.m_valid_o && mready) xfers++;
      if (own < 0) begin
         got = 0;
         for (int k = 1; k <= N; k++) begin
            c = (last_own + k) % N;
            if (!got && v[c]) begin
               got  = 1;
               own  = c;
               cred = weight(qos_in[c]);
            end
         end
      end else if (acc >= 0) begin
         b  = src_q[acc].pop_front();
         ev = 1; ed = b.data; eq = qos_in[acc]; eid = acc; el = b.last;
         if (b.last) begin
            mid = 0;
            cred--;
            if (cred == 0) begin last_own = own; own = -1; end
         end else begin
            mid = 1;
         end
      end else if (!mid && !v[own]) begin
         last_own = own;
         own      = -1;
      end
      if (acc < 0 && mready) ev = 0;
      last_acc = acc;
      @(posedge clk);
      #1;
      chk("m_valid", 32'(bus.m_valid_o), 32'(ev));
      if (ev) begin
         chk("m_data", 32'(bus.m_data_o), 32'(ed));
         chk("m_qos",  32'(bus.m_qos_o),  32'(eq));
         chk("m_id",   32'(bus.m_id_o),   32'(eid));
         chk("m_last", 32'(bus.m_last_o), 32'(el));
      end
      if (acc >= 0) obs_ids.push_back(int'(bus.m_id_o));
   endtask

   // Asserts reset at the current time, checks the cleared outputs, releases between edges.
   task automatic do_reset();
      rst_n = 1'b0;
      for (int s = 0; s < N; s++) begin
         src_q[s].delete();
         want[s]   = 0;
         qos_in[s] = '0;
      end
      mready = 1'b1;
      drive();
      #1;
      chk("rst_m_valid", 32'(bus.m_valid_o), 32'd0);
      chk("rst_s_ready", 32'(bus.s_ready_o), 32'd0);
      chk("rst_m_data",  32'(bus.m_data_o),  32'd0);
      chk("rst_m_qos",   32'(bus.m_qos_o),   32'd0);
      chk("rst_m_id",    32'(bus.m_id_o),    32'd0);
      chk("rst_m_last",  32'(bus.m_last_o),  32'd0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
      obs_ids.delete();
      xfers     = 0;
      beats_gen = 0;
      @(posedge clk);
      #1;
   endtask

   task automatic check_seq(input string tag);
      chk({tag, "_len"}, 32'(obs_ids.size()), 32'(exp_ids.size()));
      for (int i = 0; i < exp_ids.size() && i < obs_ids.size(); i++)
         chk({tag, "_id"}, 32'(obs_ids[i]), 32'(exp_ids[i]));
   endtask

   task automatic drain(input string tag, input int bound);
      int n;
      int pending;
      n = 0;
      for (int s = 0; s < N; s++) want[s] = 1;
      mready = 1'b1;
      pending = 1;
      while (pending != 0 && n < bound) begin
         pending = ev ? 1 : 0;
         for (int s = 0; s < N; s++) pending += src_q[s].size();
         if (pending != 0) begin
            step();
            n++;
         end
      end
      chk({tag, "_timeout"}, 32'(n >= bound), 32'd0);
      chk({tag, "_xfers"}, 32'(xfers), 32'(beats_gen));
   endtask

   initial begin
      int   gap, cnt;
      logic [DW-1:0] held;

      // Equal weights of 2, single-beat packets, both streams always valid.
      do_reset();
      qos_in[0] = 4'd2; qos_in[1] = 4'd2;
      for (int p = 0; p < 4; p++) begin add_pkt(0, 1); add_pkt(1, 1); end
      want[0] = 1; want[1] = 1;
      repeat (20) step();
`ifdef WRR_QOS_WEIGHT_EN
      exp_ids = '{0, 0, 1, 1, 0, 0, 1, 1};
`else
      exp_ids = '{0, 1, 0, 1, 0, 1, 0, 1};
`endif
      check_seq("equal_qos");

      // Weight 3 against weight 0 (which still earns one packet).
      do_reset();
      qos_in[0] = 4'd3; qos_in[1] = 4'd0;
      for (int p = 0; p < 6; p++) add_pkt(0, 1);
      for (int p = 0; p < 2; p++) add_pkt(1, 1);
      want[0] = 1; want[1] = 1;
      repeat (24) step();
`ifdef WRR_QOS_WEIGHT_EN
      exp_ids = '{0, 0, 0, 1, 0, 0, 0, 1};
`else
      exp_ids = '{0, 1, 0, 1, 0, 0, 0, 0};
`endif
      check_seq("qos3_qos0");

      // 4-beat packet with a two-cycle valid gap after beat 2 must not be interrupted.
      do_reset();
      qos_in[0] = 4'd1; qos_in[1] = 4'd1;
      add_pkt(0, 4);
      add_pkt(1, 1); add_pkt(1, 1);
      want[1] = 1;
      gap = 0; cnt = 0;
      for (int i = 0; i < 20; i++) begin
         want[0] = (gap == 0);
         step();
         if (gap > 0) gap--;
         if (last_acc == 0) begin
            cnt++;
            if (cnt == 2) gap = 2;
         end
      end
      exp_ids = '{0, 0, 0, 0, 1, 1};
      check_seq("gap_lock");

      // Downstream stall for three cycles holds the output and blocks the source.
      do_reset();
      qos_in[0] = 4'd2; qos_in[1] = 4'd2;
      for (int p = 0; p < 3; p++) add_pkt(0, 2);
      for (int p = 0; p < 2; p++) add_pkt(1, 1);
      want[0] = 1; want[1] = 1;
      for (int i = 0; i < 10 && !ev; i++) step();
      chk("stall_setup", 32'(ev), 32'd1);
      held   = ed;
      mready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("stall_data",  32'(bus.m_data_o),  32'(held));
         chk("stall_ready", 32'(bus.s_ready_o), 32'd0);
      end
      drain("stall", 80);

      // Weight 4 stream goes quiet after one packet, then returns for a fresh credit.
      do_reset();
      qos_in[0] = 4'd4; qos_in[1] = 4'd1;
      add_pkt(0, 1);
      add_pkt(1, 1); add_pkt(1, 1);
      want[0] = 1; want[1] = 1;
      repeat (4) step();
      for (int p = 0; p < 4; p++) add_pkt(0, 1);
      repeat (30) step();
`ifdef WRR_QOS_WEIGHT_EN
      exp_ids = '{0, 1, 0, 0, 0, 0, 1};
`else
      exp_ids = '{0, 1, 0, 1, 0, 0, 0};
`endif
      check_seq("forfeit");

      // Reset in the middle of a packet clears outputs at once; stream 0 wins afterwards.
      do_reset();
      qos_in[0] = 4'd1; qos_in[1] = 4'd1;
      add_pkt(0, 4);
      add_pkt(1, 1);
      want[0] = 1; want[1] = 1;
      repeat (3) step();
      chk("pre_reset_valid", 32'(bus.m_valid_o), 32'd1);
      #2;
      do_reset();
      qos_in[0] = 4'd1; qos_in[1] = 4'd1;
      add_pkt(1, 1);
      add_pkt(0, 2);
      want[0] = 1; want[1] = 1;
      repeat (10) step();
      exp_ids = '{0, 0, 1};
      check_seq("after_reset");

      // Random traffic: packet lengths, valid gaps, QoS changes and backpressure.
      do_reset();
      for (int i = 0; i < 400; i++) begin
         for (int s = 0; s < N; s++) begin
            if (src_q[s].size() < 4 && ($urandom % 4) == 0) add_pkt(s, 1 + int'($urandom % 4));
            want[s]   = ($urandom % 4) != 0;
            qos_in[s] = QW'($urandom);
         end
         mready = ($urandom % 4) != 0;
         step();
      end
      drain("random", 300);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, observed=running expected=finished");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/stream_wrr_arbiter.md
# stream_wrr_arbiter

Packet-granular weighted round-robin arbiter that shares one output stream between `STREAM_COUNT` input streams. Each granted stream may send up to `s_qos_i` consecutive packets before the grant rotates, so QoS sets bandwidth share rather than strict priority. It sits between the per-source stream producers and the single downstream consumer, using the same stream signal set as the existing QoS arbiter. The output is registered: one cycle of latency, full throughput.

## Interface
- `T_DATA_WIDTH`, 8, data beat width.
- `T_QOS__WIDTH`, 4, QoS field width; also the credit counter width.
- `STREAM_COUNT`, 2, number of input streams; must be ≥2.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `s_data_i` in `T_DATA_WIDTH` ×`STREAM_COUNT` (unpacked array): input data.
- `s_qos_i` in `T_QOS__WIDTH` ×`STREAM_COUNT`: per-stream QoS (packet weight).
- `s_last_i` in `STREAM_COUNT`: last beat of packet.
- `s_valid_i` in `STREAM_COUNT`: input valid.
- `s_ready_o` out `STREAM_COUNT`: input ready; one-hot or zero.
- `m_data_o` out `T_DATA_WIDTH`: output data.
- `m_qos_o` out `T_QOS__WIDTH`: QoS of the output beat.
- `m_id_o` out `$clog2(STREAM_COUNT)`: source stream index.
- `m_last_o` out 1: output last.
- `m_valid_o` out 1: output valid.
- `m_ready_i` in 1: downstream ready.

## Operation
- A beat transfers on `valid & ready`. The arbiter never drops or duplicates beats.
- FSM states: `IDLE` and `BURST`.
- **IDLE**
  - If any `s_valid_i` is high, grant the first valid stream searching from `last_id+1` mod N.
  - Load `credit = (qos==0) ? 1 : qos` from that stream's `s_qos_i`.
  - Go to `BURST`. No beat is accepted in this cycle.
- **BURST**
  - `s_ready_o[grant] = !m_valid_o | m_ready_i`; all other ready bits are 0.
  - On an accepted beat, the output register loads data, qos, last, and `id=grant`.
  - `in_pkt` is set on an accepted non-last beat and cleared on an accepted last beat.
  - On an accepted last beat: `credit--`. If the result is 0, set `last_id=grant` and go to `IDLE`.
  - If `in_pkt=0` and `s_valid_i[grant]=0`, forfeit the remaining credit, set `last_id=grant`, and go to `IDLE`.
  - If `in_pkt=1`, the grant is locked regardless of valid gaps. There is no mid-packet switch.
- Output register: `m_valid_o` is set on an accepted input beat and cleared on `m_ready_i` when no new beat loads. Output signals hold while `m_valid_o & !m_ready_i`.
- A request arriving on any stream during `BURST` waits for the rotation. Simultaneous requests in `IDLE` resolve by rotating priority only.
- QoS is sampled only at grant time. Changes during `BURST` do not affect the current credit.

## Timing
- Reset values:
  - All outputs 0: `s_ready_o`, `m_data_o`, `m_qos_o`, `m_id_o`, `m_last_o`, `m_valid_o`.
  - Internal: state `IDLE`, `credit=0`, `in_pkt=0`, `last_id=STREAM_COUNT-1`, so stream 0 wins first.
- Input-to-output latency: 1 cycle.
- Throughput within a burst: 1 beat/cycle with `m_ready_i` held high.
- Each grant costs one `IDLE` bubble cycle.
- Reset mid-packet: outputs clear immediately (asynchronous). The partial packet is abandoned and upstream must resend.
- `s_ready_o` depends combinationally on `m_ready_i`. There is no combinational path from `s_valid_i` to `s_ready_o`.

## Configuration
- `WRR_QOS_WEIGHT_EN`
  - Defined: credit loads from `s_qos_i` as above (weighted round-robin).
  - Undefined: credit is always 1, giving plain per-packet round-robin. `m_qos_o` still passes through.

## Structure
- Package `stream_arb_pkg` holds:
  - the FSM state enum (`IDLE`, `BURST`);
  - the credit-width localparam helper;
  - a function `qos_to_credit` (maps 0 to 1).
- Sub-module `rr_pick`: combinational rotating priority encoder. Inputs are the valid vector and `last_id`; outputs are `found` and `idx`.

## Test plan
- Streams 0 and 1 continuously valid, single-beat packets, `qos=2` both, `m_ready_i=1` → `m_id_o` sequence 0,0,1,1,0,0… with one bubble between groups.
- Stream 0 `qos=3`, stream 1 `qos=0` → sequence 0,0,0,1,0,0,0,1. With `WRR_QOS_WEIGHT_EN` undefined → 0,1,0,1.
- Stream 0 sends a 4-beat packet with a 2-cycle valid gap after beat 2, while stream 1 is valid throughout → all 4 beats appear with id 0 contiguous in order; stream 1 is granted only after `m_last_o`.
- `m_ready_i` low for 3 cycles while `m_valid_o=1` → `m_data_o` stable and `s_ready_o=0`; afterwards every beat appears exactly once.
- Stream 0 `qos=4` drops valid after its first packet → arbiter returns to `IDLE`, stream 1 is granted after 1 bubble, and stream 0 next gets a fresh credit of 4.
- `rst_n` pulsed low mid-packet → `m_valid_o` and `s_ready_o` go to 0 immediately; after release, stream 0 is granted first.
